// File: rtl/game_turn_ctrl.sv
// Turn sequencer for a board game: rotates the turn among the players, counts accepted moves,
// forfeits a turn on timeout and records a win or a draw. Every output comes from a flop.
module game_turn_ctrl #(
  parameter int NUM_PLAYERS = 2,
  parameter int CELLS       = 9,
  parameter int TIMEOUT     = 1000,
  localparam int PW = ($clog2(NUM_PLAYERS) > 1) ? $clog2(NUM_PLAYERS) : 1,
  localparam int CW = $clog2(CELLS + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   move_valid,
  input  logic [PW-1:0]          move_player,
  input  logic                   illegal_move,
  input  logic                   win,
  output logic [NUM_PLAYERS-1:0] play_en,
  output logic [PW-1:0]          cur_player,
  output logic [CW-1:0]          move_count,
  output logic                   game_done,
  output logic                   winner_valid,
  output logic [PW-1:0]          winner,
  output logic                   draw,
  output logic                   timeout_skip
);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, TURN, DONE} state_t;

  state_t                   state, state_n;
  logic [TW-1:0]            timer, timer_n;
  logic [PW-1:0]            cp_n, winner_n, next_player;
  logic [CW-1:0]            mc_n, mc_inc;
  logic [NUM_PLAYERS-1:0]   pe_n;
  logic                     wv_n, draw_n, ts_n, gd_n, accept;
  logic [NUM_PLAYERS-1:0]   one_hot;

  assign one_hot     = {{(NUM_PLAYERS-1){1'b0}}, 1'b1};
  assign next_player = (cur_player == PW'(NUM_PLAYERS - 1)) ? '0 : cur_player + PW'(1);
  assign mc_inc      = move_count + CW'(1);
  assign accept      = move_valid && (move_player == cur_player) && !illegal_move;

  always_comb begin
    state_n  = state;
    cp_n     = cur_player;
    mc_n     = move_count;
    timer_n  = timer;
    wv_n     = winner_valid;
    winner_n = winner;
    draw_n   = draw;
    ts_n     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n  = TURN;
          cp_n     = '0;
          mc_n     = '0;
          timer_n  = '0;
          wv_n     = 1'b0;
          winner_n = '0;
          draw_n   = 1'b0;
        end
      end
      TURN: begin
        if (accept) begin
          mc_n    = mc_inc;
          timer_n = '0;
          if (win) begin
            state_n  = DONE;
            wv_n     = 1'b1;
            winner_n = cur_player;
          end else if (mc_inc == CW'(CELLS)) begin
            state_n = DONE;
            draw_n  = 1'b1;
          end else begin
            cp_n = next_player;
          end
        end else if (timer == TW'(TIMEOUT - 1)) begin
          // a move landing on the last timer cycle wins over the forfeit
          cp_n    = next_player;
          timer_n = '0;
          ts_n    = 1'b1;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    pe_n = (state_n == TURN) ? (one_hot << cp_n) : '0;
    gd_n = (state_n == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      timer        <= '0;
      play_en      <= '0;
      cur_player   <= '0;
      move_count   <= '0;
      game_done    <= 1'b0;
      winner_valid <= 1'b0;
      winner       <= '0;
      draw         <= 1'b0;
      timeout_skip <= 1'b0;
    end else begin
      state        <= state_n;
      timer        <= timer_n;
      play_en      <= pe_n;
      cur_player   <= cp_n;
      move_count   <= mc_n;
      game_done    <= gd_n;
      winner_valid <= wv_n;
      winner       <= winner_n;
      draw         <= draw_n;
      timeout_skip <= ts_n;
    end
  end
endmodule

// File: tb/tb_game_turn_ctrl.sv
// Scoreboard bench for game_turn_ctrl: three instances (default, 3 players/TIMEOUT=8, TIMEOUT=4),
// directed stimulus pushes hand-computed expectations, a negedge monitor pops and compares.
module tb_game_turn_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, mv = 1'b0, ill = 1'b0, wn = 1'b0;
  logic [1:0] mp = '0;
  logic       st0 = 1'b0, st1 = 1'b0, st2 = 1'b0;

  logic [1:0] pe0, pe2;
  logic [2:0] pe1;
  logic       cp0, cp2, w0, w2;
  logic [1:0] cp1, w1;
  logic [3:0] mc0, mc1, mc2;
  logic       gd0, gd1, gd2, wv0, wv1, wv2, dr0, dr1, dr2, ts0, ts1, ts2;

  game_turn_ctrl u0 (
    .clk(clk), .rst(rst), .start(st0), .move_valid(mv), .move_player(mp[0]),
    .illegal_move(ill), .win(wn), .play_en(pe0), .cur_player(cp0), .move_count(mc0),
    .game_done(gd0), .winner_valid(wv0), .winner(w0), .draw(dr0), .timeout_skip(ts0));

  game_turn_ctrl #(.NUM_PLAYERS(3), .TIMEOUT(8)) u1 (
    .clk(clk), .rst(rst), .start(st1), .move_valid(mv), .move_player(mp),
    .illegal_move(ill), .win(wn), .play_en(pe1), .cur_player(cp1), .move_count(mc1),
    .game_done(gd1), .winner_valid(wv1), .winner(w1), .draw(dr1), .timeout_skip(ts1));

  game_turn_ctrl #(.TIMEOUT(4)) u2 (
    .clk(clk), .rst(rst), .start(st2), .move_valid(mv), .move_player(mp[0]),
    .illegal_move(ill), .win(wn), .play_en(pe2), .cur_player(cp2), .move_count(mc2),
    .game_done(gd2), .winner_valid(wv2), .winner(w2), .draw(dr2), .timeout_skip(ts2));

  typedef struct {
    int       id;
    string    name;
    logic [7:0] pe, cp, mc, gd, wv, w, dr, ts;
  } snap_t;

  snap_t q[$];
  int checks = 0, failures = 0;

  task automatic expect_st(input int id, input string name, input int pe, input int cp,
                           input int mc, input int gd, input int wv, input int w,
                           input int dr, input int ts);
    snap_t s;
    s.id = id; s.name = name;
    s.pe = 8'(pe); s.cp = 8'(cp); s.mc = 8'(mc); s.gd = 8'(gd);
    s.wv = 8'(wv); s.w = 8'(w); s.dr = 8'(dr); s.ts = 8'(ts);
    q.push_back(s);
  endtask

  function automatic snap_t sample(input int id);
    snap_t a;
    a.id = id; a.name = "";
    case (id)
      0: begin a.pe=8'(pe0); a.cp=8'(cp0); a.mc=8'(mc0); a.gd=8'(gd0); a.wv=8'(wv0); a.w=8'(w0); a.dr=8'(dr0); a.ts=8'(ts0); end
      1: begin a.pe=8'(pe1); a.cp=8'(cp1); a.mc=8'(mc1); a.gd=8'(gd1); a.wv=8'(wv1); a.w=8'(w1); a.dr=8'(dr1); a.ts=8'(ts1); end
      default: begin a.pe=8'(pe2); a.cp=8'(cp2); a.mc=8'(mc2); a.gd=8'(gd2); a.wv=8'(wv2); a.w=8'(w2); a.dr=8'(dr2); a.ts=8'(ts2); end
    endcase
    return a;
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0) begin
      snap_t e, a;
      e = q.pop_front();
      a = sample(e.id);
      checks++;
      if ({a.pe,a.cp,a.mc,a.gd,a.wv,a.w,a.dr,a.ts} !== {e.pe,e.cp,e.mc,e.gd,e.wv,e.w,e.dr,e.ts}) begin
        failures++;
        $display("FAIL %s dut%0d: got pe=%0h cp=%0d mc=%0d gd=%0d wv=%0d w=%0d dr=%0d ts=%0d, want pe=%0h cp=%0d mc=%0d gd=%0d wv=%0d w=%0d dr=%0d ts=%0d",
                 e.name, e.id, a.pe, a.cp, a.mc, a.gd, a.wv, a.w, a.dr, a.ts,
                 e.pe, e.cp, e.mc, e.gd, e.wv, e.w, e.dr, e.ts);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); rst = 1'b0;
  endtask

  task automatic move(input int p, input bit bad, input bit w);
    mv = 1'b1; mp = 2'(p); ill = bad; wn = w; step();
    mv = 1'b0; ill = 1'b0; wn = 1'b0; mp = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    // reset state on all instances
    do_reset();
    expect_st(0, "reset0", 0, 0, 0, 0, 0, 0, 0, 0);
    expect_st(1, "reset1", 0, 0, 0, 0, 0, 0, 0, 0);
    expect_st(2, "reset2", 0, 0, 0, 0, 0, 0, 0, 0);

    // full board, no winner -> draw
    st0 = 1'b1; step(); st0 = 1'b0;
    expect_st(0, "draw_start", 1, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 9; k++) begin
      move((k - 1) % 2, 1'b0, 1'b0);
      if (k < 9) expect_st(0, $sformatf("draw_mv%0d", k), (k % 2) ? 2 : 1, k % 2, k, 0, 0, 0, 0, 0);
      else       expect_st(0, "draw_end", 0, 0, 9, 1, 0, 0, 1, 0);
    end
    idle(2);
    expect_st(0, "draw_hold", 0, 0, 9, 1, 0, 0, 1, 0);

    // P0 wins on move 5, then restart clears the result
    do_reset();
    st0 = 1'b1; step(); st0 = 1'b0;
    for (int k = 1; k <= 4; k++) move((k - 1) % 2, 1'b0, 1'b0);
    expect_st(0, "win_mv4", 1, 0, 4, 0, 0, 0, 0, 0);
    move(0, 1'b0, 1'b1);
    expect_st(0, "win_end", 0, 0, 5, 1, 1, 0, 0, 0);
    st0 = 1'b1; step(); st0 = 1'b0;
    expect_st(0, "restart", 1, 0, 0, 0, 0, 0, 0, 0);

    // win on the last cell takes priority over draw; winner is P0
    for (int k = 1; k <= 8; k++) move((k - 1) % 2, 1'b0, 1'b0);
    move(0, 1'b0, 1'b1);
    expect_st(0, "win_last_cell", 0, 0, 9, 1, 1, 0, 0, 0);

    // three players, TIMEOUT=8: forfeits rotate the turn
    do_reset();
    st1 = 1'b1; step(); st1 = 1'b0;
    expect_st(1, "to_start", 1, 0, 0, 0, 0, 0, 0, 0);
    idle(7);
    expect_st(1, "to_pre", 1, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    expect_st(1, "to_skip1", 2, 1, 0, 0, 0, 0, 0, 1);
    idle(1);
    expect_st(1, "to_pulse_end", 2, 1, 0, 0, 0, 0, 0, 0);
    idle(7);
    expect_st(1, "to_skip2", 4, 2, 0, 0, 0, 0, 0, 1);
    idle(8);
    expect_st(1, "to_wrap", 1, 0, 0, 0, 0, 0, 0, 1);

    // illegal and out-of-turn moves are ignored; start in TURN ignored
    do_reset();
    st0 = 1'b1; step(); st0 = 1'b0;
    move(0, 1'b1, 1'b0);
    expect_st(0, "illegal", 1, 0, 0, 0, 0, 0, 0, 0);
    move(1, 1'b0, 1'b1);
    expect_st(0, "wrong_player", 1, 0, 0, 0, 0, 0, 0, 0);
    move(0, 1'b0, 1'b0);
    expect_st(0, "legal_after", 2, 1, 1, 0, 0, 0, 0, 0);
    st0 = 1'b1; step(); st0 = 1'b0;
    expect_st(0, "start_in_turn", 2, 1, 1, 0, 0, 0, 0, 0);

    // TIMEOUT=4: move on the last timer cycle beats the forfeit
    do_reset();
    st2 = 1'b1; step(); st2 = 1'b0;
    idle(3);
    move(0, 1'b0, 1'b0);
    expect_st(2, "move_at_limit", 2, 1, 1, 0, 0, 0, 0, 0);
    idle(3);
    expect_st(2, "timer_restarted", 2, 1, 1, 0, 0, 0, 0, 0);
    idle(1);
    expect_st(2, "skip_after_move", 1, 0, 1, 0, 0, 0, 0, 1);
    rst = 1'b1; step(); rst = 1'b0;
    expect_st(2, "rst_midgame", 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    expect_st(2, "idle_after_rst", 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1; st2 = 1'b1; step(); rst = 1'b0; st2 = 1'b0;
    expect_st(2, "rst_over_start", 0, 0, 0, 0, 0, 0, 0, 0);

    @(negedge clk); #1;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
